// File: rtl/playfield_arbiter.sv
// playfield_arbiter
// Shares port A of the 1024x8 synchronous playfield RAM between video tile
// fetch, the CPU and an optional bulk-clear engine. One access per clock.
// Read data comes straight from the RAM output. The matching rvalid is
// registered one cycle behind the grant.
// Optional feature: define PF_CLEAR_EN to build the bulk-clear engine.
module playfield_arbiter #(
    parameter int unsigned MAX_CPU_WAIT = 4,
    parameter logic [7:0]  CLR_VAL      = 8'h00
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       vid_req,
    input  logic [9:0] vid_addr,
    output logic       vid_rvalid,
    output logic [7:0] vid_rdata,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [9:0] ram_addr,
    output logic       ram_we_l,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_CPU_WAIT);

    logic       in_clear;
    logic       vid_gnt;
    logic       cpu_gnt;
    logic       clr_wr;
    logic [9:0] clr_addr;
    logic [3:0] wait_cnt;
    logic [9:0] addr_q;
    logic [7:0] din_q;
    logic       vid_vld_p1;
    logic       cpu_vld_p1;

`ifdef PF_CLEAR_EN
    typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] clr_cnt;
    logic       clr_last;
    logic       clr_done_p1;

    assign clr_last = clr_wr && (clr_cnt == 10'h3FF);

    // State register; reset abandons any clear in progress
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state <= SERVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clr_start only matters in SERVE, the clear ends after address 1023
    always_comb begin
        state_nxt = state;
        case (state)
            SERVE:   if (clr_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last)  state_nxt = SERVE;
            default: state_nxt = SERVE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        in_clear = (state == CLEAR);
        clr_busy = (state == CLEAR);
        clr_addr = clr_cnt;
    end

    // Clear address counter (wraps to 0 after 1023) and the done pulse
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            clr_cnt     <= 10'd0;
            clr_done_p1 <= 1'b0;
        end else begin
            if (clr_wr) clr_cnt <= clr_cnt + 10'd1;
            clr_done_p1 <= clr_last;
        end
    end

    assign clr_done = clr_done_p1;
`else
    logic unused_clr;

    assign unused_clr = clr_start;
    assign in_clear   = 1'b0;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign clr_addr   = 10'd0;
`endif

    // Pick at most one winner for this cycle's RAM access
    always_comb begin
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        clr_wr  = 1'b0;
        if (in_clear) begin
            // Video keeps priority during a clear; the CPU waits it out
            if (vid_req) vid_gnt = 1'b1;
            else         clr_wr  = 1'b1;
        end else if (cpu_req && (wait_cnt == WAIT_MAX)) begin
            // Starved CPU wins; a colliding video fetch is dropped
            cpu_gnt = 1'b1;
        end else if (vid_req) begin
            vid_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end
    end

    // Drive RAM port A from the winner; when idle, hold the last address/data
    always_comb begin
        ram_addr = addr_q;
        ram_din  = din_q;
        ram_we_l = 1'b1;
        if (vid_gnt) begin
            ram_addr = vid_addr;
        end else if (cpu_gnt) begin
            ram_addr = cpu_addr;
            if (cpu_we) begin
                ram_we_l = 1'b0;
                ram_din  = cpu_wdata;
            end
        end else if (clr_wr) begin
            ram_addr = clr_addr;
            ram_we_l = 1'b0;
            ram_din  = CLR_VAL;
        end
    end

    // Last-driven address/data and the read-valid flags one cycle behind the grant
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            addr_q     <= 10'd0;
            din_q      <= 8'h00;
            vid_vld_p1 <= 1'b0;
            cpu_vld_p1 <= 1'b0;
        end else begin
            addr_q     <= ram_addr;
            din_q      <= ram_din;
            vid_vld_p1 <= vid_gnt;
            cpu_vld_p1 <= cpu_gnt && !cpu_we;
        end
    end

    // CPU starvation counter: counts lost cycles in SERVE, frozen during a clear
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wait_cnt <= 4'd0;
        end else if (!cpu_req || cpu_gnt) begin
            wait_cnt <= 4'd0;
        end else if (!in_clear && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign cpu_ack    = cpu_gnt;
    assign vid_rvalid = vid_vld_p1;
    assign cpu_rvalid = cpu_vld_p1;
    assign vid_rdata  = ram_dout;
    assign cpu_rdata  = ram_dout;

endmodule

// File: tb/tb_playfield_arbiter.sv
// tb_playfield_arbiter
// Directed bench for playfield_arbiter with a behavioural 1024x8 synchronous
// RAM on port A. Clear-engine scenarios run when PF_CLEAR_EN is defined.
module tb_playfield_arbiter;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       vid_req;
    logic [9:0] vid_addr;
    logic       vid_rvalid;
    logic [7:0] vid_rdata;
    logic       cpu_req;
    logic       cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic [9:0] ram_addr;
    logic       ram_we_l;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [1024];

    int vectors    = 0;
    int miscompares = 0;

    playfield_arbiter dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_we_l   (ram_we_l),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write, registered output
    always @(posedge clk) begin
        if (!ram_we_l) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let combinational outputs settle
    task automatic go(input logic vr, input logic [9:0] va, input logic cr, input logic cw,
                      input logic [9:0] ca, input logic [7:0] cd, input logic cs);
        @(negedge clk);
        vid_req   = vr;
        vid_addr  = va;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        clr_start = cs;
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 1024; i++) mem[i] = 8'hC3;
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
    endtask

    initial begin
        int nz;
        int done_c;
        int vr_cnt;

        preload();
        rst_l = 1'b0;
        vid_req = 1'b0; vid_addr = 10'd0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 10'd0; cpu_wdata = 8'h00; clr_start = 1'b0;

        // Reset state
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("rst ram_we_l", ram_we_l, 1);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_din", ram_din, 0);
        chk("rst cpu_ack", cpu_ack, 0);
        chk("rst vid_rvalid", vid_rvalid, 0);
        chk("rst cpu_rvalid", cpu_rvalid, 0);
        chk("rst clr_busy", clr_busy, 0);
        chk("rst clr_done", clr_done, 0);
        rst_l = 1'b1;

        // CPU write 0xA5 to 0x3FF, then read it back
        go(0, 10'h000, 1, 1, 10'h3FF, 8'hA5, 0);
        chk("wr cpu_ack", cpu_ack, 1);
        chk("wr ram_we_l", ram_we_l, 0);
        chk("wr ram_addr", ram_addr, 10'h3FF);
        chk("wr ram_din", ram_din, 8'hA5);
        go(0, 10'h000, 1, 0, 10'h3FF, 8'h00, 0);
        chk("rd cpu_ack", cpu_ack, 1);
        chk("rd ram_we_l", ram_we_l, 1);
        chk("wr no rvalid", cpu_rvalid, 0);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("rd cpu_rvalid", cpu_rvalid, 1);
        chk("rd cpu_rdata", cpu_rdata, 8'hA5);
        chk("idle ram_we_l", ram_we_l, 1);
        chk("idle addr hold", ram_addr, 10'h3FF);
        chk("idle cpu_ack", cpu_ack, 0);

        // Video beats CPU, CPU served once video drops
        go(1, 10'h010, 1, 0, 10'h020, 8'h00, 0);
        chk("prio ram_addr", ram_addr, 10'h010);
        chk("prio no ack", cpu_ack, 0);
        go(0, 10'h000, 1, 0, 10'h020, 8'h00, 0);
        chk("prio late ack", cpu_ack, 1);
        chk("prio cpu addr", ram_addr, 10'h020);
        chk("prio vid_rvalid", vid_rvalid, 1);
        chk("prio vid_rdata", vid_rdata, 8'hC3);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("prio cpu_rvalid", cpu_rvalid, 1);
        chk("prio vid done", vid_rvalid, 0);

        // Starvation guard: 4 lost cycles, then a forced grant that drops video
        for (int i = 0; i < 4; i++) begin
            go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
            chk("starve lose", cpu_ack, 0);
            chk("starve vid addr", ram_addr, 10'h002);
        end
        go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
        chk("starve forced ack", cpu_ack, 1);
        chk("starve cpu addr", ram_addr, 10'h001);
        chk("starve prev vid", vid_rvalid, 1);
        go(1, 10'h002, 0, 0, 10'h000, 8'h00, 0);
        chk("starve cpu_rvalid", cpu_rvalid, 1);
        chk("starve cpu_rdata", cpu_rdata, 8'h22);
        chk("starve vid dropped", vid_rvalid, 0);
        // Counter restarted from 0: another 4 losses before the next forced grant
        for (int i = 0; i < 4; i++) begin
            go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
            chk("restart lose", cpu_ack, 0);
        end
        go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
        chk("restart forced ack", cpu_ack, 1);

        // Reset during starvation clears the wait counter
        for (int i = 0; i < 3; i++) go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
        go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
        chk("rstmid no ack", cpu_ack, 0);
        rst_l = 1'b0;
        go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
        rst_l = 1'b1;
        chk("rstmid vid_rvalid", vid_rvalid, 0);
        chk("rstmid lose1", cpu_ack, 0);
        for (int i = 0; i < 3; i++) begin
            go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
            chk("rstmid lose", cpu_ack, 0);
        end
        go(1, 10'h002, 1, 0, 10'h001, 8'h00, 0);
        chk("rstmid forced ack", cpu_ack, 1);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);

        // Back-to-back video reads of 0,1,2
        go(1, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("b2b addr0", ram_addr, 10'h000);
        chk("b2b rvalid0", vid_rvalid, 0);
        go(1, 10'h001, 0, 0, 10'h000, 8'h00, 0);
        chk("b2b rvalid1", vid_rvalid, 1);
        chk("b2b rdata1", vid_rdata, 8'h11);
        go(1, 10'h002, 0, 0, 10'h000, 8'h00, 0);
        chk("b2b rvalid2", vid_rvalid, 1);
        chk("b2b rdata2", vid_rdata, 8'h22);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("b2b rvalid3", vid_rvalid, 1);
        chk("b2b rdata3", vid_rdata, 8'h33);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("b2b rvalid end", vid_rvalid, 0);

`ifdef PF_CLEAR_EN
        // Full clear with no other traffic
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 1);
        chk("clr start busy", clr_busy, 0);
        for (int k = 0; k < 1024; k++) begin
            go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
            chk("clr busy", clr_busy, 1);
            chk("clr we_l", ram_we_l, 0);
            chk("clr addr", ram_addr, k);
            chk("clr din", ram_din, 8'h00);
            chk("clr no done", clr_done, 0);
        end
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("clr done", clr_done, 1);
        chk("clr busy drop", clr_busy, 0);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("clr done pulse", clr_done, 0);
        nz = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h00) nz++;
        chk("clr nonzero locs", nz, 0);
        go(1, 10'h3FF, 0, 0, 10'h000, 8'h00, 0);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("clr rd rvalid", vid_rvalid, 1);
        chk("clr rd data", vid_rdata, 8'h00);

        // Clear with video every 4th cycle: 341 video grants delay done to 1366
        preload();
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 1);
        done_c = 0;
        vr_cnt = 0;
        for (int c = 1; c <= 2000; c++) begin
            go((c % 4) == 0, 10'(c), 0, 0, 10'h000, 8'h00, 0);
            if (vid_rvalid) vr_cnt++;
            if (clr_done) begin
                done_c = c;
                break;
            end
        end
        chk("clrv done cycle", done_c, 1366);
        chk("clrv vid rvalids", vr_cnt, 341);

        // Reset while clearing address 0x200; CPU is served immediately after
        preload();
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 1);
        for (int k = 0; k <= 16'h200; k++) go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("rclr addr", ram_addr, 10'h200);
        chk("rclr we_l", ram_we_l, 0);
        rst_l = 1'b0;
        go(0, 10'h000, 1, 0, 10'h005, 8'h00, 0);
        rst_l = 1'b1;
        chk("rclr busy", clr_busy, 0);
        chk("rclr cpu_ack", cpu_ack, 1);
        chk("rclr we_l idle", ram_we_l, 1);
        chk("rclr cpu addr", ram_addr, 10'h005);
        chk("rclr mem 1ff", mem[10'h1FF], 8'h00);
        chk("rclr mem 200", mem[10'h200], 8'h00);
        chk("rclr mem 201", mem[10'h201], 8'hC3);
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("rclr no done", clr_done, 0);
`else
        // Without the clear engine clr_start is ignored
        go(0, 10'h000, 1, 1, 10'h100, 8'h5C, 1);
        chk("noclr ack", cpu_ack, 1);
        chk("noclr we_l", ram_we_l, 0);
        for (int i = 0; i < 3; i++) begin
            go(0, 10'h000, 1, 0, 10'h100, 8'h00, 0);
            chk("noclr busy", clr_busy, 0);
            chk("noclr done", clr_done, 0);
            chk("noclr cpu ack", cpu_ack, 1);
            chk("noclr cpu addr", ram_addr, 10'h100);
        end
        go(0, 10'h000, 0, 0, 10'h000, 8'h00, 0);
        chk("noclr rdata", cpu_rdata, 8'h5C);
        chk("noclr mem intact", mem[10'h101], 8'hC3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/playfield_arbiter.md
Name: playfield_arbiter

Overview:
- Shares the single read/write port (port A) of the 1024x8 synchronous playfield RAM between three sources: video tile fetch, CPU, and a bulk-clear engine.
- Issues at most one RAM access per clock.
- Returns read data one cycle after the grant, matching the RAM's registered output.
- Sits between the CPU bus decode, the video tile fetcher and the playfield RAM; port B of the RAM is not touched.

Parameters:
- MAX_CPU_WAIT, 4: consecutive cycles a pending CPU request may lose to video before it is forced a grant (range 1-15).
- CLR_VAL, 8'h00: byte written to every location by the clear engine.

Ports:
- clk  in  1  system clock
- rst_l  in  1  synchronous active-low reset, sampled on posedge clk
- vid_req  in  1  video fetch request, single cycle per access
- vid_addr  in  10  video fetch address
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  8  video read data
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  10  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  CPU access granted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  8  CPU read data
- clr_start  in  1  pulse: begin a full-RAM clear (PF_CLEAR_EN only)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- ram_addr  out  10  to RAM addrA
- ram_we_l  out  1  to RAM write enable, active low
- ram_din  out  8  to RAM datain
- ram_dout  in  8  from RAM dataA; valid the cycle after the address is presented

Behaviour:
- Reset values: ram_we_l=1, ram_addr=0, ram_din=0, all ack/rvalid/done outputs 0, clr_busy=0, wait counter 0, clear counter 0, state SERVE.
- Grant cycle N: the arbiter drives ram_addr, ram_we_l and ram_din combinationally from the winning requester.
- Read data: the rvalid for the cycle-N grant is registered and asserts in cycle N+1. rdata equals ram_dout in that cycle; no extra register on the data itself.
- Writes: ram_we_l=0 only in the grant cycle of a write. Writes produce no rvalid.
- State SERVE, priority order:
  1. CPU, if cpu_req and wait_cnt==MAX_CPU_WAIT.
  2. Video, if vid_req.
  3. CPU, if cpu_req.
  4. Otherwise idle: ram_we_l=1, ram_addr holds its last value.
- wait_cnt (4 bits):
  - increments on every cycle cpu_req=1 and the CPU loses;
  - clears on cpu_ack or when cpu_req=0;
  - saturates at MAX_CPU_WAIT.
- Video dropping: a vid_req that loses to a forced CPU grant is dropped. vid_rvalid stays 0 in N+1, and the fetcher must re-request.
- cpu_ack is asserted in the grant cycle. The CPU may drop or change its request in the next cycle; back-to-back CPU grants are allowed.
- State CLEAR (entered from SERVE when clr_start=1; takes effect the next cycle):
  - clr_busy=1.
  - Video keeps top priority.
  - CPU is never granted; its request stays pending and wait_cnt does not count.
  - In every cycle without vid_req: write CLR_VAL at clr_cnt, then clr_cnt++.
  - After writing address 1023: clr_cnt wraps to 0, clr_done pulses the next cycle, clr_busy drops in that same cycle, and the state returns to SERVE.
- clr_start asserted while already in CLEAR is ignored.
- If clr_start and cpu_req are asserted in the same SERVE cycle, that cycle is arbitrated normally, and CLEAR begins the next cycle.
- Reset mid-operation: everything returns to reset values at the next edge and a clear in progress is abandoned. The RAM contents are left partially cleared.
- Simultaneous grant and response: a new grant may occur in the same cycle as the previous grant's rvalid (full throughput, one access per cycle).

Optional Feature:
- Macro PF_CLEAR_EN.
- Defined: the CLEAR state, clear counter, clr_start/clr_busy/clr_done behave as above.
- Undefined: the clear logic is not built; clr_start is ignored and clr_busy/clr_done are tied to 0. Ports are kept so the interface is identical in both builds.

Test Plan:
- CPU write then read: write 8'hA5 to 10'h3FF, then read 10'h3FF -> cpu_ack in each grant cycle, ram_we_l=0 only on the write, cpu_rvalid=1 with cpu_rdata=8'hA5 one cycle after the read grant.
- Priority: vid_req and cpu_req in the same cycle (vid_addr=10'h010) -> video granted, ram_addr=10'h010, no cpu_ack; CPU granted the next cycle once vid_req drops.
- Starvation guard: vid_req held continuously, cpu_req held, MAX_CPU_WAIT=4 -> cpu_ack after exactly 4 lost cycles; the vid_req in that cycle gets no vid_rvalid; wait_cnt returns to 0.
- Back-to-back video reads at addresses 0,1,2 -> vid_rvalid high for 3 consecutive cycles, lagging the grants by 1, with data matching preloaded RAM contents.
- Clear (PF_CLEAR_EN): preload nonzero, pulse clr_start with no other traffic -> 1024 writes of CLR_VAL, clr_done pulses exactly 1025 cycles after clr_start (one entry cycle plus 1024 writes); every location reads 8'h00. Repeat with video requests every 4th cycle -> done is delayed by the number of video grants.
- Reset mid-clear: deassert rst_l at clear address 10'h200 -> next cycle clr_busy=0, ram_we_l=1, state SERVE, and CPU accesses are served immediately.
